pe_col_sched: RTL and testbench
===============================

// Module: pe_col_sched
// PURPOSE
//  Sequencer for one column of NPE chained PE MAC stages (lane k oPsum -> lane k+1 iPsum; lane 0 iPsum tied to 0).
//  On start it issues NumVec reads from the X/W buffers, one per cycle. Each read returns NPE lanes.
//  Drives the skewed per-lane enables and flags the column output with a valid/index pair.
//  Pulses done after the pipeline drains. The column cannot stall, so the downstream sink accepts every valid.
// PARAMETERS
//  NPE    8   PE stages in the column (chain depth, lanes)
//  AW     10  X/W buffer address width
//  TW     10  vector-count width
//  RD_LAT 1   buffer read latency in cycles (>=1)
// PORTS
//  iCLK      in   1      clock
//  iRSTn     in   1      async active-low reset
//  iStart    in   1      start request, sampled only in IDLE
//  iNumVec   in   TW     dot products to compute, latched at start
//  iXBase    in   AW     X buffer base address, latched at start
//  iWBase    in   AW     W buffer base address, latched at start
//  oBusy     out  1      job in progress
//  oDone     out  1      1-cycle pulse at job end
//  oRdEn     out  1      X/W buffer read strobe
//  oXAddr    out  AW     X read address
//  oWAddr    out  AW     W read address
//  oLaneEn   out  NPE    bit k: lane k input valid this cycle (skew control)
//  oOutValid out  1      oPsum of lane NPE-1 holds a finished dot product
//  oOutIdx   out  TW     vector index of that result
// BEHAVIOUR
//  Reset (async, iRSTn=0): state IDLE. All outputs 0. Counters, latched config and skew/valid pipes cleared.
//   Reset mid-job aborts the job with no oDone. PE contents are don't-care.
//  FSM IDLE -> ISSUE -> DRAIN -> FIN -> IDLE.
//   IDLE:  iStart=1 with iNumVec>0: latch config, go ISSUE. iStart=1 with iNumVec=0: go FIN, no reads issued.
//   ISSUE: one read per cycle for v=0..NumVec-1. oRdEn=1, oXAddr=XBase+v, oWAddr=WBase+v (mod 2^AW wrap).
//          After v=NumVec-1, go DRAIN.
//   DRAIN: oRdEn=0. Wait until the valid pipe is empty, i.e. the last oOutValid has been emitted. Then go FIN.
//   FIN:   oDone=1 for one cycle, oBusy=0. Return to IDLE.
//  oBusy=1 in ISSUE and DRAIN only. iStart while busy is ignored, not queued. iStart in FIN is ignored.
//  Timing: c0 = cycle iStart is seen; first read at c0+1.
//   For a read issued at cycle t: oLaneEn[k]=1 at t+RD_LAT+k.
//   oOutValid=1 with oOutIdx=v at t+RD_LAT+NPE.
//  Back-to-back reads give back-to-back valids, with no bubbles.
//  oOutIdx is carried through a TW-bit pipe matched to the oOutValid pipe.
//  Issue counter is TW bits. The maximum job is 2^TW-1 vectors. Address arithmetic truncates to AW.
//  Latched config is immune to input changes during a job.
// CONFIGURATION
//  SCHED_PERF_EN defined: adds output oCycCnt [31:0]. It is cleared at job start and increments every cycle oBusy=1.
//   It saturates at all-ones and holds its value after oDone until the next start. Reset value 0.
//  SCHED_PERF_EN undefined: no port, no counter logic. All other behaviour is identical.
// STRUCTURE
//  Package pe_sched_pkg:
//   - state enum {IDLE, ISSUE, DRAIN, FIN}.
//   - localparam PIPE_LAT = RD_LAT+NPE.
//   - shared defaults for NPE/AW/TW.
//  Sub-module pe_skew_pipe:
//   - generic 1-bit+payload delay line of configurable depth with async clear.
//   - used for oLaneEn taps (depth RD_LAT..RD_LAT+NPE-1) and the oOutValid/oOutIdx pipe (depth PIPE_LAT).
//  Top-level module holds the FSM, the counters and the address adders.
// TESTING (NPE=8, RD_LAT=1 unless noted)
//  1 NumVec=1, XBase=0x10, WBase=0x20, start at c0:
//    rd at c0+1 with X=0x10, W=0x20. LaneEn[k] at c0+2+k.
//    OutValid with idx 0 at c0+10. oDone at c0+11. oBusy high c0+1..c0+10.
//  2 NumVec=4: rdEn c0+1..c0+4 with addresses base+0..3.
//    OutValid c0+10..c0+13 with idx 0..3. oDone at c0+14. With a PE-column model, the results match the golden dot products.
//  3 NumVec=0: no rdEn, no OutValid, oBusy stays 0, oDone at c0+1.
//  4 XBase=0x3FE, NumVec=3 (AW=10): X addresses 0x3FE, 0x3FF, 0x000.
//    A second iStart pulsed during the job is ignored, and exactly one oDone follows.
//  5 Assert iRSTn=0 at c0+5 of a NumVec=4 job: all outputs 0 immediately (async).
//    No oDone. After release, a new start behaves as scenario 1.
//  6 SCHED_PERF_EN defined, NumVec=4: oCycCnt=13 after oDone. It holds its value until the next start, which clears it.

Source files
------------

// File: rtl/pe_sched_pkg.sv
// Shared types and default sizing for the PE column scheduler.
package pe_sched_pkg;

  localparam int unsigned NPE_DEF    = 8;
  localparam int unsigned AW_DEF     = 10;
  localparam int unsigned TW_DEF     = 10;
  localparam int unsigned RD_LAT_DEF = 1;

  // Read-to-result latency for the default column geometry.
  localparam int unsigned PIPE_LAT = RD_LAT_DEF + NPE_DEF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } state_e;

  // Read-to-result latency for an arbitrary column geometry.
  function automatic int unsigned pipe_lat(input int unsigned rd_lat, input int unsigned npe);
    return rd_lat + npe;
  endfunction

endpackage

// File: rtl/pe_skew_pipe.sv
// Valid + payload delay line; every valid stage is exposed as a tap so the
// caller can pick per-lane skewed enables and the final result strobe.
module pe_skew_pipe #(
  parameter int unsigned DEPTH = 9,
  parameter int unsigned PW    = 10
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             vld_i,
  input  logic [PW-1:0]    pld_i,
  output logic [DEPTH-1:0] vld_tap_o,
  output logic [PW-1:0]    pld_o
);

  logic [DEPTH-1:0] vld_q;
  logic [PW-1:0]    pld_q [DEPTH];

  // Shift valid and payload one stage per cycle; payload is zeroed when invalid.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) pld_q[i] <= '0;
    end else begin
      vld_q[0] <= vld_i;
      pld_q[0] <= vld_i ? pld_i : '0;
      for (int i = 1; i < int'(DEPTH); i++) begin
        vld_q[i] <= vld_q[i-1];
        pld_q[i] <= pld_q[i-1];
      end
    end
  end

  assign vld_tap_o = vld_q;
  assign pld_o     = pld_q[DEPTH-1];

endmodule

// File: rtl/pe_col_sched.sv
// Sequencer for one column of chained PE MAC stages: issues X/W buffer reads,
// drives the skewed lane enables and tags finished dot products with an index.
// Optional build macro SCHED_PERF_EN adds the oCycCnt busy-cycle counter.
module pe_col_sched
  import pe_sched_pkg::*;
#(
  parameter int unsigned NPE    = NPE_DEF,
  parameter int unsigned AW     = AW_DEF,
  parameter int unsigned TW     = TW_DEF,
  parameter int unsigned RD_LAT = RD_LAT_DEF
) (
  input  logic          iCLK,
  input  logic          iRSTn,
  input  logic          iStart,
  input  logic [TW-1:0] iNumVec,
  input  logic [AW-1:0] iXBase,
  input  logic [AW-1:0] iWBase,
  output logic          oBusy,
  output logic          oDone,
  output logic          oRdEn,
  output logic [AW-1:0] oXAddr,
  output logic [AW-1:0] oWAddr,
  output logic [NPE-1:0] oLaneEn,
  output logic          oOutValid,
  output logic [TW-1:0] oOutIdx
`ifdef SCHED_PERF_EN
  ,
  output logic [31:0]   oCycCnt
`endif
);

  localparam int unsigned LAT = pipe_lat(RD_LAT, NPE);

  state_e        state_q;
  logic [TW-1:0] vcnt_q;
  logic [TW-1:0] num_vec_q;
  logic [AW-1:0] x_base_q;
  logic [AW-1:0] w_base_q;
  logic          rd_en_q;
  logic [AW-1:0] x_addr_q;
  logic [AW-1:0] w_addr_q;
  logic [TW-1:0] rd_idx_q;
  logic          busy_q;
  logic          done_q;

  logic [AW-1:0] x_addr_d;
  logic [AW-1:0] w_addr_d;
  logic [LAT-1:0] vld_tap;
  logic [TW-1:0] out_idx;
  logic          pipe_pending;

  // Next read addresses, wrapping modulo 2^AW.
  always_comb begin
    x_addr_d = x_base_q + AW'(vcnt_q);
    w_addr_d = w_base_q + AW'(vcnt_q);
  end

  // Anything short of the final stage still in flight keeps the job draining.
  assign pipe_pending = |vld_tap[LAT-2:0];

  // Job control FSM with registered read strobe, addresses, busy and done.
  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      state_q   <= IDLE;
      vcnt_q    <= '0;
      num_vec_q <= '0;
      x_base_q  <= '0;
      w_base_q  <= '0;
      rd_en_q   <= 1'b0;
      x_addr_q  <= '0;
      w_addr_q  <= '0;
      rd_idx_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (iStart) begin
            if (iNumVec != '0) begin
              num_vec_q <= iNumVec;
              x_base_q  <= iXBase;
              w_base_q  <= iWBase;
              rd_en_q   <= 1'b1;
              x_addr_q  <= iXBase;
              w_addr_q  <= iWBase;
              rd_idx_q  <= '0;
              vcnt_q    <= TW'(1);
              busy_q    <= 1'b1;
              state_q   <= ISSUE;
            end else begin
              done_q  <= 1'b1;
              state_q <= FIN;
            end
          end
        end
        ISSUE: begin
          if (vcnt_q == num_vec_q) begin
            rd_en_q <= 1'b0;
            state_q <= DRAIN;
          end else begin
            rd_en_q  <= 1'b1;
            x_addr_q <= x_addr_d;
            w_addr_q <= w_addr_d;
            rd_idx_q <= vcnt_q;
            vcnt_q   <= vcnt_q + TW'(1);
          end
        end
        DRAIN: begin
          if (!pipe_pending) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= FIN;
          end
        end
        FIN: begin
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Read strobe and index travel together; taps give lane skew and result valid.
  pe_skew_pipe #(
    .DEPTH (LAT),
    .PW    (TW)
  ) u_skew (
    .clk_i     (iCLK),
    .rst_ni    (iRSTn),
    .vld_i     (rd_en_q),
    .pld_i     (rd_idx_q),
    .vld_tap_o (vld_tap),
    .pld_o     (out_idx)
  );

  assign oBusy     = busy_q;
  assign oDone     = done_q;
  assign oRdEn     = rd_en_q;
  assign oXAddr    = x_addr_q;
  assign oWAddr    = w_addr_q;
  assign oLaneEn   = vld_tap[RD_LAT+NPE-2:RD_LAT-1];
  assign oOutValid = vld_tap[LAT-1];
  assign oOutIdx   = out_idx;

`ifdef SCHED_PERF_EN
  logic [31:0] cyc_q;

  // Busy-cycle counter: cleared on an accepted start, saturating, held after done.
  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      cyc_q <= '0;
    end else if (state_q == IDLE && iStart) begin
      cyc_q <= '0;
    end else if (busy_q && cyc_q != '1) begin
      cyc_q <= cyc_q + 32'd1;
    end
  end

  assign oCycCnt = cyc_q;
`endif

endmodule

// File: tb/tb_pe_col_sched.sv
// Directed bench for pe_col_sched (NPE=8, AW=TW=10, RD_LAT=1) with a small
// PE-column model that turns the issued addresses into dot products.
module tb_pe_col_sched;

  localparam int NPE = 8;
  localparam int AW  = 10;
  localparam int TW  = 10;

  logic          clk;
  logic          rst_n;
  logic          iStart;
  logic [TW-1:0] iNumVec;
  logic [AW-1:0] iXBase;
  logic [AW-1:0] iWBase;
  logic          oBusy;
  logic          oDone;
  logic          oRdEn;
  logic [AW-1:0] oXAddr;
  logic [AW-1:0] oWAddr;
  logic [NPE-1:0] oLaneEn;
  logic          oOutValid;
  logic [TW-1:0] oOutIdx;
`ifdef SCHED_PERF_EN
  logic [31:0]   oCycCnt;
`endif

  int n_checks;
  int n_fail;

  pe_col_sched dut (
    .iCLK      (clk),
    .iRSTn     (rst_n),
    .iStart    (iStart),
    .iNumVec   (iNumVec),
    .iXBase    (iXBase),
    .iWBase    (iWBase),
    .oBusy     (oBusy),
    .oDone     (oDone),
    .oRdEn     (oRdEn),
    .oXAddr    (oXAddr),
    .oWAddr    (oWAddr),
    .oLaneEn   (oLaneEn),
    .oOutValid (oOutValid),
    .oOutIdx   (oOutIdx)
`ifdef SCHED_PERF_EN
    ,
    .oCycCnt   (oCycCnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Buffer contents as pure functions of address and lane.
  function automatic int xval(input int a, input int k);
    return (a * 5 + k * 11 + 3) & 255;
  endfunction

  function automatic int wval(input int a, input int k);
    return ((a * 7) ^ (k * 13)) & 255;
  endfunction

  function automatic int golden(input int xa, input int wa);
    int s;
    s = 0;
    for (int k = 0; k < NPE; k++) s += xval(xa, k) * wval(wa, k);
    return s;
  endfunction

  // PE column model: RD_LAT=1 buffer, lane k MACs with the read address from k+1 cycles back.
  logic [AW-1:0] xah [NPE];
  logic [AW-1:0] wah [NPE];
  logic [31:0]   psum [NPE];

  always @(posedge clk) begin
    xah[0] <= oXAddr;
    wah[0] <= oWAddr;
    for (int j = 1; j < NPE; j++) begin
      xah[j] <= xah[j-1];
      wah[j] <= wah[j-1];
    end
    if (oLaneEn[0]) psum[0] <= 32'(xval(int'(xah[0]), 0) * wval(int'(wah[0]), 0));
    for (int k = 1; k < NPE; k++)
      if (oLaneEn[k]) psum[k] <= psum[k-1] + 32'(xval(int'(xah[k]), k) * wval(int'(wah[k]), k));
  end

  // Present one start pulse; returns at the negedge inside cycle c0+1.
  task automatic start_job(input int n, input int xb, input int wb);
    @(negedge clk);
    iStart  = 1'b1;
    iNumVec = TW'(n);
    iXBase  = AW'(xb);
    iWBase  = AW'(wb);
    @(negedge clk);
    iStart  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; iStart = 1'b0; iNumVec = '0; iXBase = '0; iWBase = '0;
    #2;
    n_checks++;
    if ({oBusy, oDone, oRdEn, oOutValid, oLaneEn, oXAddr, oWAddr, oOutIdx} !== '0) begin
      n_fail++;
      $display("FAIL reset_async got busy=%b done=%b rd=%b val=%b lane=%h x=%h w=%h idx=%h exp all 0",
               oBusy, oDone, oRdEn, oOutValid, oLaneEn, oXAddr, oWAddr, oOutIdx);
    end
    repeat (3) @(negedge clk);
    iStart = 1'b1; iNumVec = TW'(3);
    @(negedge clk);
    n_checks++;
    if ({oBusy, oDone, oRdEn, oOutValid, oLaneEn} !== '0) begin
      n_fail++;
      $display("FAIL reset_held got busy=%b done=%b rd=%b val=%b lane=%h exp all 0",
               oBusy, oDone, oRdEn, oOutValid, oLaneEn);
    end
`ifdef SCHED_PERF_EN
    n_checks++;
    if (oCycCnt !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_cyccnt got %0d exp 0", oCycCnt);
    end
`endif
    iStart = 1'b0;
    rst_n  = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // One job of n vectors; optional extra start pulse at cycle 'poke' (0 = none).
  task automatic test_job(input int n, input int xb, input int wb, input int poke, input string tag);
    int v, lk, done_c;
    logic exp_rd, exp_val, exp_busy, exp_done;
    logic [NPE-1:0] exp_lane;
    done_c = (n > 0) ? n + 10 : 1;
    start_job(n, xb, wb);
    for (int c = 1; c <= n + 16; c++) begin
      exp_rd   = (c <= n);
      v        = c - 10;
      exp_val  = (v >= 0 && v < n);
      exp_busy = (n > 0 && c <= n + 9);
      exp_done = (c == done_c);
      for (int k = 0; k < NPE; k++) begin
        lk = c - 2 - k;
        exp_lane[k] = (lk >= 0 && lk < n);
      end
      n_checks++;
      if (oRdEn !== exp_rd) begin
        n_fail++; $display("FAIL %s rden c=%0d got %b exp %b", tag, c, oRdEn, exp_rd);
      end
      if (exp_rd) begin
        n_checks++;
        if (oXAddr !== AW'(xb + c - 1) || oWAddr !== AW'(wb + c - 1)) begin
          n_fail++;
          $display("FAIL %s addr c=%0d got x=%h w=%h exp x=%h w=%h", tag, c, oXAddr, oWAddr,
                   AW'(xb + c - 1), AW'(wb + c - 1));
        end
      end
      n_checks++;
      if (oLaneEn !== exp_lane) begin
        n_fail++; $display("FAIL %s laneen c=%0d got %b exp %b", tag, c, oLaneEn, exp_lane);
      end
      n_checks++;
      if (oOutValid !== exp_val) begin
        n_fail++; $display("FAIL %s outvalid c=%0d got %b exp %b", tag, c, oOutValid, exp_val);
      end
      if (exp_val) begin
        n_checks++;
        if (oOutIdx !== TW'(v)) begin
          n_fail++; $display("FAIL %s outidx c=%0d got %0d exp %0d", tag, c, oOutIdx, v);
        end
        n_checks++;
        if (psum[NPE-1] !== 32'(golden((xb + v) & 1023, (wb + v) & 1023))) begin
          n_fail++;
          $display("FAIL %s dotprod idx=%0d got %0d exp %0d", tag, v, psum[NPE-1],
                   golden((xb + v) & 1023, (wb + v) & 1023));
        end
      end
      n_checks++;
      if (oBusy !== exp_busy) begin
        n_fail++; $display("FAIL %s busy c=%0d got %b exp %b", tag, c, oBusy, exp_busy);
      end
      n_checks++;
      if (oDone !== exp_done) begin
        n_fail++; $display("FAIL %s done c=%0d got %b exp %b", tag, c, oDone, exp_done);
      end
`ifdef SCHED_PERF_EN
      if (c == 1) begin
        n_checks++;
        if (oCycCnt !== 32'd0) begin
          n_fail++; $display("FAIL %s cyccnt_clear got %0d exp 0", tag, oCycCnt);
        end
      end else if (c >= done_c) begin
        n_checks++;
        if (oCycCnt !== 32'((n > 0) ? n + 9 : 0)) begin
          n_fail++;
          $display("FAIL %s cyccnt c=%0d got %0d exp %0d", tag, c, oCycCnt, (n > 0) ? n + 9 : 0);
        end
      end
`endif
      if (c == poke) begin
        iStart = 1'b1; iNumVec = TW'(2); iXBase = AW'(10'h155); iWBase = AW'(10'h0AA);
      end else if (c == poke + 1) begin
        iStart = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_midjob_reset();
    start_job(4, 'h40, 'h80);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({oBusy, oDone, oRdEn, oOutValid, oLaneEn, oXAddr, oWAddr, oOutIdx} !== '0) begin
      n_fail++;
      $display("FAIL midreset_async got busy=%b done=%b rd=%b val=%b lane=%h x=%h w=%h idx=%h exp all 0",
               oBusy, oDone, oRdEn, oOutValid, oLaneEn, oXAddr, oWAddr, oOutIdx);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 16; c++) begin
      n_checks++;
      if (oDone !== 1'b0 || oBusy !== 1'b0 || oOutValid !== 1'b0) begin
        n_fail++;
        $display("FAIL midreset_quiet c=%0d got done=%b busy=%b val=%b exp 0 0 0",
                 c, oDone, oBusy, oOutValid);
      end
      @(negedge clk);
    end
    test_job(1, 'h10, 'h20, 0, "post_reset");
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_job(1,  'h10,  'h20,  0,  "single");
    test_job(4,  'h10,  'h20,  0,  "four");
    test_job(0,  'h10,  'h20,  0,  "zero");
    test_job(3,  'h3FE, 'h005, 3,  "wrap_ignore_busy");
    test_job(2,  'h100, 'h3FF, 12, "ignore_in_fin");
    test_job(20, 'h030, 'h200, 0,  "back_to_back");
    test_midjob_reset();
    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
